// File: rtl/sipo_pkg.sv
// sipo_pkg: shared types and constants for the serial-link deserializer.
//   state_t          - shift FSM states (IDLE: no bits held, SHIFT: partial word)
//   SIPO_WIDTH_DEF   - default word length
//   MSB_FIRST_ON/OFF - bit-order selection values for the MSB_FIRST parameter
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int SIPO_WIDTH_DEF = 4;

  localparam bit MSB_FIRST_ON  = 1'b1;  // first bit received lands in po[WIDTH-1]
  localparam bit MSB_FIRST_OFF = 1'b0;  // first bit received lands in po[0]

endpackage

// File: rtl/sipo_deser.sv
// sipo_deser: serial-in/parallel-out deserializer, receive end of the serial link.
// Assembles WIDTH qualified serial bits into a word and holds it on po under a
// valid/ready handshake. A word that completes while the previous one is still
// unaccepted is dropped and flagged on the sticky overrun bit.
// Ports:
//   clk, reset_n     - clock, asynchronous active-low reset
//   si, si_valid     - serial bit and its qualifier
//   sof              - start of frame (with si_valid): si is bit 0 of a new word
//   po, po_valid     - assembled word and its valid
//   po_ready         - consumer accepts po this cycle
//   overrun, clr_ovr - sticky drop flag and its synchronous clear
//   busy             - partial word in progress
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = SIPO_WIDTH_DEF,
  parameter bit MSB_FIRST = MSB_FIRST_ON
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             si,
  input  logic             si_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] po,
  output logic             po_valid,
  input  logic             po_ready,
  output logic             overrun,
  input  logic             clr_ovr,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg, sh_base, sh_nxt;
  logic             complete, load, drop;

  // A resync starts from an empty register so stale partial bits can never
  // leak into the next word.
  always_comb begin
    sh_base = sof ? '0 : shreg;
    if (MSB_FIRST) sh_nxt = {sh_base[WIDTH-2:0], si};
    else           sh_nxt = {si, sh_base[WIDTH-1:1]};
  end

  // sof always restarts at count 1, so it can never complete a word (WIDTH >= 2).
  assign complete = si_valid && !sof && (cnt_q == LAST);
  assign load     = complete && (!po_valid || po_ready);
  assign drop     = complete && po_valid && !po_ready;
  assign busy     = (cnt_q != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (si_valid) begin
      if (sof) begin
        state_d = SHIFT;
        cnt_d   = CW'(1);
      end else begin
        case (state_q)
          IDLE: begin
            state_d = SHIFT;
            cnt_d   = CW'(1);
          end
          SHIFT: begin
            if (cnt_q == LAST) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d   = cnt_q + CW'(1);
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg    <= '0;
      po       <= '0;
      po_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (si_valid) shreg <= sh_nxt;
      // po is only written on load, so it stays stable while stalled and
      // keeps its last value after acceptance.
      if (load) begin
        po       <= sh_nxt;
        po_valid <= 1'b1;
      end else if (po_ready) begin
        po_valid <= 1'b0;
      end
      // set wins over clear
      if (drop)         overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
    end
  end

endmodule
